// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
// Index p of each per-port vector belongs to requester p (0 or 1).
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][WIDTH-1:0]  req_srca;
    logic [1:0][WIDTH-1:0]  req_srcb;
    logic [1:0][3:0]        req_ctrl;
    logic [1:0][4:0]        req_shamt;
    logic [1:0]             rsp_valid;
    logic [1:0]             rsp_ready;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_zero;
    logic                   rsp_err;

    // Requester side
    modport master (
        output req_valid, req_srca, req_srcb, req_ctrl, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_srca, req_srcb, req_ctrl, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational alu32 between two requesters. One operation is in
// flight at a time: IDLE grants and latches operands, EXEC lets the ALU settle
// and captures its result, RESP presents the result until the owner takes it.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_share_arbiter_if.slave    bus,
    output logic [WIDTH-1:0]      alu_srca,
    output logic [WIDTH-1:0]      alu_srcb,
    output logic [3:0]            alu_control,
    output logic [4:0]            alu_shamt,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero,
    output logic                  busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             owner;
    logic             rr_ptr;
    logic [1:0]       grant;
    logic             gsel;
    logic             accept;

    logic [WIDTH-1:0] srca_p0;
    logic [WIDTH-1:0] srcb_p0;
    logic [3:0]       ctrl_p0;
    logic [4:0]       shamt_p0;

    logic [WIDTH-1:0] result_p1;
    logic             zero_p1;
    logic             err_p1;

    // alu32 has no defined behaviour for this opcode group
    function automatic logic is_unsupported(input logic [3:0] ctrl);
        return (ctrl[2:0] == 3'b011);
    endfunction

    // Unsupported ops report a clean zero rather than whatever the ALU emits
    function automatic logic [WIDTH-1:0] gate_result(input logic [WIDTH-1:0] res,
                                                     input logic             err);
        return err ? '0 : res;
    endfunction

    // Pick at most one requester while idle; ties go to the port not served last
    always_comb begin
        grant = 2'b00;
        gsel  = 1'b0;
        if (rst_n && state == IDLE) begin
            case (bus.req_valid)
                2'b01:   gsel = 1'b0;
                2'b10:   gsel = 1'b1;
                2'b11:   gsel = RR_EN ? ~rr_ptr : 1'b0;
                default: gsel = 1'b0;
            endcase
            if (bus.req_valid != 2'b00) begin
                grant = gsel ? 2'b10 : 2'b01;
            end
        end
    end

    assign accept         = |grant;
    assign bus.req_ready  = grant;
    assign bus.rsp_valid  = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_result = result_p1;
    assign bus.rsp_zero   = zero_p1;
    assign bus.rsp_err    = err_p1;
    assign busy           = (state != IDLE);

    assign alu_srca    = srca_p0;
    assign alu_srcb    = srcb_p0;
    assign alu_control = ctrl_p0;
    assign alu_shamt   = shamt_p0;

    // Operation sequencing, ownership and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= gsel;
                        state <= EXEC;
                    end
                end
                EXEC: state <= RESP;
                RESP: begin
                    if (bus.rsp_ready[owner]) begin
                        rr_ptr <= owner;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand latch on accept, result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srca_p0   <= '0;
            srcb_p0   <= '0;
            ctrl_p0   <= '0;
            shamt_p0  <= '0;
            result_p1 <= '0;
            zero_p1   <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            // p0: operands from the granted port drive the ALU through EXEC
            if (accept) begin
                srca_p0  <= bus.req_srca[gsel];
                srcb_p0  <= bus.req_srcb[gsel];
                ctrl_p0  <= bus.req_ctrl[gsel];
                shamt_p0 <= bus.req_shamt[gsel];
            end
            // p1: settled ALU output is frozen for the response phase
            if (state == EXEC) begin
                result_p1 <= gate_result(alu_result, is_unsupported(ctrl_p0));
                zero_p1   <= alu_zero;
                err_p1    <= is_unsupported(ctrl_p0);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin instance exercised with directed
// and random transactions against a transaction-level model, plus a
// fixed-priority instance checked for port-0 preference.
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(W)) bif ();
    alu_share_arbiter_if #(.WIDTH(W)) fif ();

    logic [W-1:0] r_srca, r_srcb, r_res;
    logic [3:0]   r_ctl;
    logic [4:0]   r_sh;
    logic         r_zero, r_busy;

    logic [W-1:0] f_srca, f_srcb, f_res;
    logic [3:0]   f_ctl;
    logic [4:0]   f_sh;
    logic         f_zero, f_busy;

    alu_share_arbiter #(.WIDTH(W), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(bif),
        .alu_srca(r_srca), .alu_srcb(r_srcb), .alu_control(r_ctl), .alu_shamt(r_sh),
        .alu_result(r_res), .alu_zero(r_zero), .busy(r_busy)
    );

    alu_share_arbiter #(.WIDTH(W), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n), .bus(fif),
        .alu_srca(f_srca), .alu_srcb(f_srcb), .alu_control(f_ctl), .alu_shamt(f_sh),
        .alu_result(f_res), .alu_zero(f_zero), .busy(f_busy)
    );

    // Behavioural alu32 stand-in; the unsupported opcode returns junk on purpose
    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] c, input logic [4:0] s);
        case (c[2:0])
            3'b000:  return c[3] ? a - b : a + b;
            3'b001:  return b << s;
            3'b010:  return ($signed(a) < $signed(b)) ? 1 : 0;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a ^ b;
            3'b111:  return b >> s;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        r_res  = alu_ref(r_srca, r_srcb, r_ctl, r_sh);
        r_zero = (r_res == '0);
        f_res  = alu_ref(f_srca, f_srcb, f_ctl, f_sh);
        f_zero = (f_res == '0);
    end

    int n_cmp = 0;
    int n_bad = 0;
    int last_port;
    logic [W-1:0] opa [2];
    logic [W-1:0] opb [2];
    logic [3:0]   opc [2];
    logic [4:0]   ops [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_ops();
        for (int p = 0; p < 2; p++) begin
            opa[p] = $urandom;
            opb[p] = ($urandom_range(0, 3) == 0) ? opa[p] : $urandom;
            opc[p] = 4'($urandom_range(0, 15));
            ops[p] = 5'($urandom_range(0, 31));
        end
    endtask

    // One full transaction on the round-robin instance, checked end to end
    task automatic run_op(input logic [1:0] vld, input int hold, output int gport);
        int         exp_p;
        logic [W-1:0] raw, exp_r;
        logic       exp_e;
        bit         seen;
        logic [1:0] exp_oh;
        if (vld == 2'b01)      exp_p = 0;
        else if (vld == 2'b10) exp_p = 1;
        else                   exp_p = 1 - last_port;
        exp_oh = (exp_p == 1) ? 2'b10 : 2'b01;
        raw    = alu_ref(opa[exp_p], opb[exp_p], opc[exp_p], ops[exp_p]);
        exp_e  = (opc[exp_p][2:0] == 3'b011);
        exp_r  = exp_e ? '0 : raw;
        gport  = -1;

        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            bif.req_srca[p]  = opa[p];
            bif.req_srcb[p]  = opb[p];
            bif.req_ctrl[p]  = opc[p];
            bif.req_shamt[p] = ops[p];
        end
        bif.req_valid = vld;
        bif.rsp_ready = 2'b00;

        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bif.req_ready != 2'b00) seen = 1'b1;
        end
        if (!seen) begin
            chk("grant_timeout", 0, 1);
            bif.req_valid = 2'b00;
            return;
        end
        chk("grant", bif.req_ready, exp_oh);
        gport = bif.req_ready[1] ? 1 : 0;

        @(posedge clk); #1;
        bif.req_valid = 2'b00;
        @(negedge clk);
        chk("exec_busy", r_busy, 1);
        chk("exec_rspv", bif.rsp_valid, 0);
        chk("exec_srca", r_srca, opa[exp_p]);
        chk("exec_srcb", r_srcb, opb[exp_p]);
        chk("exec_ctl", r_ctl, opc[exp_p]);
        chk("exec_shamt", r_sh, ops[exp_p]);

        @(negedge clk);
        chk("rsp_valid", bif.rsp_valid, exp_oh);
        chk("rsp_result", bif.rsp_result, exp_r);
        chk("rsp_err", bif.rsp_err, exp_e);
        chk("rsp_zero", bif.rsp_zero, raw == '0);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            bif.rsp_ready = ~exp_oh;
            bif.req_valid = 2'b11;
            @(negedge clk);
            chk("hold_valid", bif.rsp_valid, exp_oh);
            chk("hold_result", bif.rsp_result, exp_r);
            chk("hold_busy", r_busy, 1);
            chk("hold_noready", bif.req_ready, 0);
        end

        @(posedge clk); #1;
        bif.req_valid = 2'b00;
        bif.rsp_ready = exp_oh;
        @(posedge clk); #1;
        bif.rsp_ready = 2'b00;
        @(negedge clk);
        chk("done_busy", r_busy, 0);
        chk("done_rspv", bif.rsp_valid, 0);
        last_port = exp_p;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int exp_ord [4];
        int grants;
        exp_ord = '{1, 0, 1, 0};

        rst_n = 1'b0;
        bif.req_valid = '0; bif.rsp_ready = '0;
        bif.req_srca = '0; bif.req_srcb = '0; bif.req_ctrl = '0; bif.req_shamt = '0;
        fif.req_valid = '0; fif.rsp_ready = '0;
        fif.req_srca = '0; fif.req_srcb = '0; fif.req_ctrl = '0; fif.req_shamt = '0;
        last_port = 0;

        repeat (2) @(posedge clk);
        #1;
        bif.req_valid = 2'b11;
        #1;
        chk("rst_ready", bif.req_ready, 0);
        chk("rst_rspv", bif.rsp_valid, 0);
        chk("rst_busy", r_busy, 0);
        chk("rst_result", bif.rsp_result, 0);
        chk("rst_srca", r_srca, 0);
        bif.req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin order with both ports valid from reset
        for (int k = 0; k < 4; k++) begin
            rand_ops();
            run_op(2'b11, 0, g);
            chk("rr_order", g, exp_ord[k]);
        end

        // Port 0 add
        rand_ops();
        opa[0] = 5; opb[0] = 3; opc[0] = 4'b0000; ops[0] = 0;
        run_op(2'b01, 0, g);
        chk("add_const", bif.rsp_result, 8);
        chk("add_zero", bif.rsp_zero, 0);

        // SUB to zero, with a long response stall
        opa[1] = 7; opb[1] = 7; opc[1] = 4'b1000; ops[1] = 0;
        run_op(2'b10, 5, g);
        chk("sub_const", bif.rsp_result, 0);
        chk("sub_zero", bif.rsp_zero, 1);

        // Signed SLT
        opa[0] = 32'hFFFF_FFFF; opb[0] = 1; opc[0] = 4'b0010;
        run_op(2'b01, 1, g);
        chk("slt_const", bif.rsp_result, 1);

        // Unsupported op
        opa[1] = 32'h1234; opb[1] = 32'h55; opc[1] = 4'b0011;
        run_op(2'b10, 0, g);
        chk("err_flag", bif.rsp_err, 1);
        chk("err_result", bif.rsp_result, 0);

        // Random traffic
        for (int k = 0; k < 20; k++) begin
            rand_ops();
            run_op(2'($urandom_range(1, 3)), $urandom_range(0, 3), g);
        end

        // Reset during EXEC: everything clears at once and the op vanishes
        opa[0] = 32'h0F0F_0F0F; opb[0] = 32'h0101_0101; opc[0] = 4'b0101; ops[0] = 0;
        @(posedge clk); #1;
        bif.req_srca[0] = opa[0]; bif.req_srcb[0] = opb[0];
        bif.req_ctrl[0] = opc[0]; bif.req_shamt[0] = ops[0];
        bif.req_valid = 2'b01;
        @(posedge clk); #1;
        chk("pre_rst_busy", r_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", r_busy, 0);
        chk("mid_rst_rspv", bif.rsp_valid, 0);
        chk("mid_rst_ready", bif.req_ready, 0);
        chk("mid_rst_result", bif.rsp_result, 0);
        chk("mid_rst_err", bif.rsp_err, 0);
        chk("mid_rst_srca", r_srca, 0);
        chk("mid_rst_ctl", r_ctl, 0);
        bif.req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_port = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_rspv", bif.rsp_valid, 0);
        end
        rand_ops();
        run_op(2'b11, 0, g);
        chk("post_rst_grant", g, 1);

        // Fixed priority: port 0 keeps winning while it stays valid
        fif.req_srca[0] = 10; fif.req_srcb[0] = 4; fif.req_ctrl[0] = 4'b1000; fif.req_shamt[0] = 0;
        fif.req_srca[1] = 1;  fif.req_srcb[1] = 2; fif.req_ctrl[1] = 4'b0000; fif.req_shamt[1] = 0;
        @(posedge clk); #1;
        fif.req_valid = 2'b11;
        fif.rsp_ready = 2'b11;
        grants = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (fif.req_ready != 2'b00) begin
                chk("fp_grant", fif.req_ready, 2'b01);
                grants++;
            end
            if (fif.rsp_valid != 2'b00) begin
                chk("fp_rspv", fif.rsp_valid, 2'b01);
                chk("fp_result", fif.rsp_result, 6);
            end
        end
        chk("fp_grant_count", grants >= 8, 1);
        @(posedge clk); #1;
        fif.req_valid = 2'b00;
        fif.rsp_ready = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
